// File: rtl/shift_cmd_sequencer.sv
// shift_cmd_sequencer: command FIFO feeding a one-stage shift/rotate execute unit.
// Each command {op, amt, data} is queued, then popped into a registered result
// slot with valid/ready handshake on both sides.
// Optional feature macro: ROTATE_EN -- ops 10/11 rotate; when undefined they
// fall back to SHL/SHR and the rotate fill paths are not built.
module shift_cmd_sequencer #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [7:0]               in_data,
   input  logic [2:0]               in_amt,
   input  logic [1:0]               in_op,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [7:0]               out_data,
   output logic                     out_zero,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

   typedef struct packed {
      logic [1:0] op;
      logic [2:0] amt;
      logic [7:0] data;
   } cmd_t;

   cmd_t          mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;
   logic [7:0]    out_data_q, out_data_d;
   logic          out_zero_q, out_zero_d;

   logic          push, pop;
   cmd_t          head;
   logic          right;
   logic [7:0]    s0, s1, s2, s3, res;
   logic          fill1;
   logic [1:0]    fill2;
   logic [3:0]    fill4;

   function automatic logic [7:0] bitrev(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   // in_ready is a register, so it only reflects occupancy after the edge.
   assign push = in_valid & in_ready_q;
   assign pop  = (level_q != '0) & (~out_valid_q | out_ready);
   assign head = mem_q[rd_ptr_q];
   assign right = head.op[0];

`ifdef ROTATE_EN
   logic rot;
   assign rot = head.op[1];
`else
   // op[1] selects rotation only in rotate builds; kept in storage regardless.
   logic unused_op1;
   assign unused_op1 = head.op[1];
`endif

   // Shifter: right ops mirror the operand so one left network serves both.
   always_comb begin
      s0 = right ? bitrev(head.data) : head.data;
`ifdef ROTATE_EN
      fill1 = rot ? s0[7]   : 1'b0;
`else
      fill1 = 1'b0;
`endif
      s1 = head.amt[0] ? {s0[6:0], fill1} : s0;
`ifdef ROTATE_EN
      fill2 = rot ? s1[7:6] : 2'b00;
`else
      fill2 = 2'b00;
`endif
      s2 = head.amt[1] ? {s1[5:0], fill2} : s1;
`ifdef ROTATE_EN
      fill4 = rot ? s2[7:4] : 4'h0;
`else
      fill4 = 4'h0;
`endif
      s3 = head.amt[2] ? {s2[3:0], fill4} : s2;
      res = right ? bitrev(s3) : s3;
   end

   // Next-state for pointers, occupancy, ready flag and result register.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_zero_d  = out_zero_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;
      if (pop) begin
         out_valid_d = 1'b1;
         out_data_d  = res;
         out_zero_d  = (res == 8'h00);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
      in_ready_d = (level_d < DEPTH_L);
   end

   // FIFO storage; contents are meaningless until written so no reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {in_op, in_amt, in_data};
   end

   // Control and result registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= 8'h00;
         out_zero_q  <= 1'b1;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_zero_q  <= out_zero_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_zero  = out_zero_q;
   assign level     = level_q;

endmodule

// File: doc/shift_cmd_sequencer.md
SHIFT_CMD_SEQUENCER -- requirements
Module: shift_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, command FIFO depth; power of two, at least 2.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1, command present.
REQ-005 The block SHALL have port in_ready, output, 1, FIFO can accept.
REQ-006 The block SHALL have port in_data, input, 8, operand.
REQ-007 The block SHALL have port in_amt, input, 3, shift amount 0..7.
REQ-008 The block SHALL have port in_op, input, 2: 00 SHL, 01 SHR logical, 10 ROL, 11 ROR.
REQ-009 The block SHALL have port out_valid, output, 1, result held.
REQ-010 The block SHALL have port out_ready, input, 1, consumer accepts.
REQ-011 The block SHALL have port out_data, output, 8, result.
REQ-012 The block SHALL have port out_zero, output, 1, high when out_data is 0x00.
REQ-013 The block SHALL have port level, output, log2(DEPTH)+1, current FIFO occupancy.

Function
REQ-014 The block SHALL accept a command on any rising edge where in_valid and in_ready are both 1; the FIFO stores {in_op, in_amt, in_data}.
REQ-015 in_ready SHALL be 1 exactly when level < DEPTH; it SHALL depend only on registered state, so a pop in the same cycle does not raise it.
REQ-016 The execute stage SHALL pop the FIFO head and load the output register on an edge where level > 0 and (out_valid = 0 or out_ready = 1).
REQ-017 Latency SHALL be one cycle: for a command accepted at edge E0 into an empty FIFO with an empty output register, out_valid SHALL rise after edge E1.
REQ-018 With out_ready held at 1, throughput SHALL be one result per cycle.
REQ-019 Results SHALL leave in acceptance order, and every accepted command SHALL produce exactly one result.
REQ-020 While out_valid = 1 and out_ready = 0, out_data, out_zero and out_valid SHALL hold stable.
REQ-021 out_valid SHALL drop after an edge with out_valid & out_ready when level = 0.
REQ-022 A simultaneous push and pop SHALL leave level unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-023 SHL and SHR SHALL zero-fill; for example, SHL of 0x81 by 1 gives 0x02.
REQ-024 ROL and ROR SHALL be 8-bit circular rotations.
REQ-025 An amount of 0 SHALL return the operand unchanged for every op.
REQ-026 Left operations SHALL use a 3-stage (1/2/4) left-shift mux network.
REQ-027 Right operations SHALL bit-reverse the operand, apply the left network, then bit-reverse the result.
REQ-028 out_zero SHALL be registered together with out_data.

Reset
REQ-029 Asserting rst SHALL immediately force in_ready = 0, out_valid = 0, out_data = 0x00, out_zero = 1, level = 0, and both pointers to 0.
REQ-030 Reset mid-operation SHALL discard all queued and held commands without producing output.
REQ-031 in_ready SHALL rise after the first rising edge with rst low.

Configuration
REQ-032 With ROTATE_EN defined, ops 10 and 11 SHALL rotate.
REQ-033 Without ROTATE_EN, op 10 SHALL behave as SHL and op 11 as SHR, and no rotate logic SHALL be synthesized.

Verification
REQ-034 Single command: push {SHL, 3, 0x15} into an idle block -> out_valid one cycle later with out_data = 0xA8 and out_zero = 0.
REQ-035 Right shift and zero result: push {SHR, 7, 0x80} then {SHR, 1, 0x01} -> 0x01 (out_zero = 0), then 0x00 (out_zero = 1), in order.
REQ-036 Rotate: push {ROL, 4, 0xA5} and {ROR, 1, 0x01} -> with ROTATE_EN: 0x5A, 0x80; without: 0x50, 0x00.
REQ-037 Backpressure and full: hold out_ready = 0 and push 6 commands, DEPTH = 4 -> 5 accepted (4 queued plus 1 held), in_ready = 0, level = 4, held output stable; release -> all 5 results delivered in order.
REQ-038 Streaming: continuous push with out_ready = 1 for 16 commands -> 16 results on consecutive cycles, level never exceeds 1.
REQ-039 Reset mid-stream: assert rst with level = 3 and out_valid = 1 -> all outputs immediately at reset values; after release no stale result appears.
